// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl - hazard and sequencing controller for a 5-stage
// MIPS pipeline (IF/ID/EX/MEM/WB).
//
// Purpose:
//   - EX-stage operand forwarding selects (MEM result has priority over WB).
//   - Load-use detection in ID, inserting LDSTALL_CYC bubbles into EX.
//   - Flush of IF/ID, ID/EX and EX/MEM on a taken branch/jump resolved in MEM.
//   - Whole-pipe freeze during memory wait states. A redirect seen while the
//     pipe is frozen is remembered and replayed as a one-cycle flush
//     (REDIRECT state) after the freeze ends.
//
// Ports:
//   clk, reset (async, active low)
//   rs_d/rt_d, uses_rs_d/uses_rt_d            ID source registers and use flags
//   rs_e/rt_e, writereg_e, regwrite_e, memtoreg_e   EX stage info
//   writereg_m/regwrite_m, writereg_w/regwrite_w    MEM/WB destinations
//   redirect_m                                taken branch/jump in MEM
//   memstall                                  memory not ready
//   stallf/stalld/stalle/stallm               hold PC and pipe registers
//   flushd/flushe/flushm                      clear pipe registers
//   forwardae/forwardbe                       00 regfile, 01 WB, 10 MEM
//   state                                     RUN=00 LDSTALL=01 MEMWAIT=10 REDIRECT=11
//
// Optional feature: define HAZARD_PERF_CNT_EN to add the free-running
// event counters ldstall_cnt, redirect_cnt and memwait_cnt (32 bit, wrapping).

// Forwarding select for one EX operand.
module pipeline_hazard_fwd #(
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] src,
  input  logic [REGW-1:0] writereg_m,
  input  logic            regwrite_m,
  input  logic [REGW-1:0] writereg_w,
  input  logic            regwrite_w,
  output logic [1:0]      sel
);
  always_comb begin
    sel = 2'b00;
    // $0 is hardwired to zero and never forwarded.
    if (regwrite_m && (writereg_m != '0) && (writereg_m == src))
      sel = 2'b10;
    else if (regwrite_w && (writereg_w != '0) && (writereg_w == src))
      sel = 2'b01;
  end
endmodule

module pipeline_hazard_ctrl #(
  parameter int REGW        = 5,
  parameter int LDSTALL_CYC = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] rs_d,
  input  logic [REGW-1:0] rt_d,
  input  logic            uses_rs_d,
  input  logic            uses_rt_d,
  input  logic [REGW-1:0] rs_e,
  input  logic [REGW-1:0] rt_e,
  input  logic [REGW-1:0] writereg_e,
  input  logic            regwrite_e,
  input  logic            memtoreg_e,
  input  logic [REGW-1:0] writereg_m,
  input  logic            regwrite_m,
  input  logic [REGW-1:0] writereg_w,
  input  logic            regwrite_w,
  input  logic            redirect_m,
  input  logic            memstall,
  output logic            stallf,
  output logic            stalld,
  output logic            stalle,
  output logic            stallm,
  output logic            flushd,
  output logic            flushe,
  output logic            flushm,
  output logic [1:0]      forwardae,
  output logic [1:0]      forwardbe,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]     ldstall_cnt,
  output logic [31:0]     redirect_cnt,
  output logic [31:0]     memwait_cnt,
`endif
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LDSTALL  = 2'b01,
    MEMWAIT  = 2'b10,
    REDIRECT = 2'b11
  } state_t;

  // Bubbles still owed after the first one (first is issued from RUN).
  localparam logic [1:0] LD_INIT = 2'(LDSTALL_CYC - 1);

  state_t     state_q, state_n;
  logic [1:0] ldcnt, ldcnt_n;
  logic       pending, pending_n;

  // One-hot-ish action for this cycle; drives all strobes.
  logic freeze, flush, bubble;
  logic lduse;

  // ---------------- forwarding ----------------
  logic [1:0][REGW-1:0] src_e;
  logic [1:0][1:0]      fwd;

  assign src_e = {rt_e, rs_e};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    pipeline_hazard_fwd #(.REGW(REGW)) u_fwd (
      .src        (src_e[g]),
      .writereg_m (writereg_m),
      .regwrite_m (regwrite_m),
      .writereg_w (writereg_w),
      .regwrite_w (regwrite_w),
      .sel        (fwd[g])
    );
  end

  // ---------------- load-use ----------------
  assign lduse = memtoreg_e && regwrite_e && (writereg_e != '0) &&
                 ((uses_rs_d && (writereg_e == rs_d)) ||
                  (uses_rt_d && (writereg_e == rt_d)));

  // ---------------- next state / action ----------------
  always_comb begin
    state_n   = state_q;
    ldcnt_n   = ldcnt;
    pending_n = pending;
    freeze    = 1'b0;
    flush     = 1'b0;
    bubble    = 1'b0;

    if (state_q == REDIRECT) begin
      if (memstall) begin
        // Freeze wins; the deferred flush stays pending.
        freeze    = 1'b1;
        pending_n = 1'b1;
        state_n   = MEMWAIT;
      end else begin
        flush     = 1'b1;
        pending_n = 1'b0;
        state_n   = RUN;
      end
    end else if (memstall) begin
      freeze    = 1'b1;
      // Sticky while frozen; sampled fresh when the freeze starts.
      pending_n = ((state_q == MEMWAIT) && pending) || redirect_m;
      ldcnt_n   = 2'd0;
      state_n   = MEMWAIT;
    end else begin
      // RUN rules; also used for the MEMWAIT exit cycle.
      if (redirect_m) begin
        flush   = 1'b1;
        ldcnt_n = 2'd0;
        state_n = RUN;
      end else if (state_q == LDSTALL) begin
        // ID/EX is flushed during the bubble, so lduse itself has gone
        // away; the remaining bubbles are driven from the counter.
        bubble  = 1'b1;
        ldcnt_n = ldcnt - 2'd1;
        state_n = (ldcnt == 2'd1) ? RUN : LDSTALL;
      end else if (lduse) begin
        bubble  = 1'b1;
        ldcnt_n = LD_INIT;
        state_n = (LDSTALL_CYC > 1) ? LDSTALL : RUN;
      end else begin
        state_n = RUN;
      end

      // Leaving a freeze with a remembered redirect: replay it next cycle.
      if ((state_q == MEMWAIT) && pending) begin
        ldcnt_n = 2'd0;
        state_n = REDIRECT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      ldcnt   <= 2'd0;
      pending <= 1'b0;
    end else begin
      state_q <= state_n;
      ldcnt   <= ldcnt_n;
      pending <= pending_n;
    end
  end

  // ---------------- outputs ----------------
  // Strobes must act in the same cycle as the event, so they are decoded
  // combinationally and forced quiet while reset is held.
  assign stallf    = reset & (freeze | bubble);
  assign stalld    = reset & (freeze | bubble);
  assign stalle    = reset & freeze;
  assign stallm    = reset & freeze;
  assign flushd    = reset & flush;
  assign flushe    = reset & (flush | bubble);
  assign flushm    = reset & flush;
  assign forwardae = reset ? fwd[0] : 2'b00;
  assign forwardbe = reset ? fwd[1] : 2'b00;
  assign state     = state_q;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ldstall_cnt  <= '0;
      redirect_cnt <= '0;
      memwait_cnt  <= '0;
    end else begin
      if (bubble)              ldstall_cnt  <= ldstall_cnt + 32'd1;
      if (flush)               redirect_cnt <= redirect_cnt + 32'd1;
      if (state_q == MEMWAIT)  memwait_cnt  <= memwait_cnt + 32'd1;
    end
  end
`endif

endmodule
